// File: rtl/deserializador_coma.sv
// Comma-aligning 10-bit deserializer: hunts for K28.5 at any bit phase,
// frames LSB-first symbols to it and drops lock after repeated misaligned commas.
module deserializador_coma #(
  parameter logic [9:0] COMMA_P  = 10'h17C,
  parameter logic [9:0] COMMA_N  = 10'h283,
  parameter int         MISS_MAX = 3
) (
  input  logic       CLOCK,
  input  logic       RESET_L,
  input  logic       IS,
  output logic [9:0] OP,
  output logic       VALID,
  output logic       K_DET,
  output logic       ALIGNED,
  output logic       MISALIGN
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  state_t     state, state_n;
  logic [9:0] sr;
  logic [3:0] ph, ph_n;
  logic [3:0] mc, mc_n;
  logic [9:0] op_n;
  logic       valid_n, k_det_n, aligned_n, misalign_n;
  logic       match;

  assign match = (sr == COMMA_P) || (sr == COMMA_N);

  always_comb begin
    state_n    = state;
    ph_n       = ph;
    mc_n       = mc;
    op_n       = OP;
    valid_n    = 1'b0;
    k_det_n    = 1'b0;
    aligned_n  = ALIGNED;
    misalign_n = 1'b0;
    case (state)
      HUNT: begin
        if (match) begin
          op_n      = sr;
          valid_n   = 1'b1;
          k_det_n   = 1'b1;
          ph_n      = 4'd0;
          mc_n      = 4'd0;
          aligned_n = 1'b1;
          state_n   = LOCKED;
        end else begin
          ph_n = 4'd0;
        end
      end
      LOCKED: begin
        ph_n = (ph == 4'd9) ? 4'd0 : ph + 4'd1;
        if (ph == 4'd9) begin
          op_n    = sr;
          valid_n = 1'b1;
          k_det_n = match;
          if (match) begin
            mc_n = 4'd0;
          end else begin
            mc_n = mc;
          end
        end else if (match) begin
          // A comma off the boundary: count it, and give up framing at the limit.
          misalign_n = 1'b1;
          if (mc + 4'd1 == MISS_LIM) begin
            state_n   = HUNT;
            aligned_n = 1'b0;
            mc_n      = 4'd0;
            ph_n      = 4'd0;
          end else begin
            mc_n = mc + 4'd1;
          end
        end else begin
          misalign_n = 1'b0;
        end
      end
      default: begin
        state_n   = HUNT;
        aligned_n = 1'b0;
        ph_n      = 4'd0;
        mc_n      = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= HUNT;
      sr       <= 10'd0;
      ph       <= 4'd0;
      mc       <= 4'd0;
      OP       <= 10'd0;
      VALID    <= 1'b0;
      K_DET    <= 1'b0;
      ALIGNED  <= 1'b0;
      MISALIGN <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= {IS, sr[9:1]};
      ph       <= ph_n;
      mc       <= mc_n;
      OP       <= op_n;
      VALID    <= valid_n;
      K_DET    <= k_det_n;
      ALIGNED  <= aligned_n;
      MISALIGN <= misalign_n;
    end
  end

endmodule

// File: tb/tb_deserializador_coma.sv
// Scoreboard bench for deserializador_coma: a bit-index framing model predicts
// every VALID/MISALIGN event and the ALIGNED level; a monitor compares them.
module tb_deserializador_coma;

  localparam logic [9:0] CP = 10'h17C;
  localparam logic [9:0] CN = 10'h283;
  localparam int         MISS_MAX = 3;

  logic       CLOCK = 1'b0;
  logic       RESET_L = 1'b0;
  logic       IS = 1'b0;
  logic [9:0] OP;
  logic       VALID, K_DET, ALIGNED, MISALIGN;

  deserializador_coma #(.COMMA_P(CP), .COMMA_N(CN), .MISS_MAX(MISS_MAX)) dut (
    .CLOCK(CLOCK), .RESET_L(RESET_L), .IS(IS), .OP(OP),
    .VALID(VALID), .K_DET(K_DET), .ALIGNED(ALIGNED), .MISALIGN(MISALIGN)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         t;
    bit         mis;
    logic [9:0] op;
    bit         k;
  } ev_t;

  ev_t  exp_q[$];
  bit   al_change[int];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b0;
  bit   cur_al = 1'b0;

  // Reference model state: the stream as a list of bits since time zero.
  bit   hist[$];
  int   base = 0;
  bit   locked = 1'b0;
  int   last_end = 0;
  int   miss = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  function automatic logic [9:0] window(input int i);
    logic [9:0] w;
    w = 10'd0;
    for (int k = 0; k < 10; k++) begin
      if (i - 9 + k >= base) w[k] = hist[i - 9 + k];
    end
    return w;
  endfunction

  // Drive one bit and predict what the block must report two edges later.
  task automatic send_bit(input bit b);
    int         i;
    logic [9:0] w;
    bit         is_comma;
    int         t;
    ev_t        e;
    IS = b;
    hist.push_back(b);
    i = hist.size() - 1;
    w = window(i);
    is_comma = (w == CP) || (w == CN);
    t = cyc + 2;
    if (!locked) begin
      if (is_comma) begin
        locked = 1'b1; last_end = i; miss = 0;
        e = '{t: t, mis: 1'b0, op: w, k: 1'b1};
        exp_q.push_back(e);
        al_change[t] = 1'b1;
      end
    end else if ((i - last_end) % 10 == 0) begin
      e = '{t: t, mis: 1'b0, op: w, k: is_comma};
      exp_q.push_back(e);
      if (is_comma) miss = 0;
    end else if (is_comma) begin
      e = '{t: t, mis: 1'b1, op: 10'd0, k: 1'b0};
      exp_q.push_back(e);
      miss++;
      if (miss == MISS_MAX) begin
        locked = 1'b0; miss = 0;
        al_change[t] = 1'b0;
      end
    end
    @(posedge CLOCK); #1;
  endtask

  task automatic send_sym(input logic [9:0] v);
    for (int k = 0; k < 10; k++) send_bit(v[k]);
  endtask

  task automatic send_rand_bits(input int n);
    for (int k = 0; k < n; k++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (OP !== 10'd0 || VALID !== 1'b0 || K_DET !== 1'b0 || ALIGNED !== 1'b0 || MISALIGN !== 1'b0) begin
      errors++;
      $display("FAIL %s: OP=%h VALID=%b K_DET=%b ALIGNED=%b MISALIGN=%b, required all 0",
               name, OP, VALID, K_DET, ALIGNED, MISALIGN);
    end
  endtask

  task automatic do_reset();
    RESET_L = 1'b0;
    exp_q.delete();
    al_change.delete();
    base = hist.size();
    locked = 1'b0; miss = 0;
    #1;
    check_reset_outputs("reset_immediate");
    @(posedge CLOCK); #1;
    RESET_L = 1'b1;
  endtask

  // Monitor: compares ALIGNED every cycle and pops an expectation per output event.
  always @(negedge CLOCK) begin
    if (!RESET_L) begin
      cur_al = 1'b0;
    end else if (running) begin
      if (al_change.exists(cyc)) cur_al = al_change[cyc];
      checks++;
      if (ALIGNED !== cur_al) begin
        errors++;
        $display("FAIL aligned cyc=%0d: got %b, required %b", cyc, ALIGNED, cur_al);
      end
      if (VALID === 1'b1 || MISALIGN === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: VALID=%b MISALIGN=%b OP=%h, none expected",
                   cyc, VALID, MISALIGN, OP);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.t != cyc || MISALIGN !== e.mis || VALID !== !e.mis ||
              (!e.mis && (OP !== e.op || K_DET !== e.k))) begin
            errors++;
            $display("FAIL event cyc=%0d: got VALID=%b MISALIGN=%b OP=%h K_DET=%b, required cyc=%0d mis=%b OP=%h K_DET=%b",
                     cyc, VALID, MISALIGN, OP, K_DET, e.t, e.mis, e.op, e.k);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event cyc=%0d: no output, required mis=%b OP=%h at cyc=%0d",
                 cyc, e.mis, e.op, e.t);
      end
    end
  end

  initial begin
    logic [9:0] v;
    RESET_L = 1'b0;
    IS = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    check_reset_outputs("reset_initial");
    RESET_L = 1'b1;
    running = 1'b1;

    // Silence never locks.
    for (int k = 0; k < 40; k++) send_bit(1'b0);
    checks++;
    if (OP !== 10'd0) begin
      errors++;
      $display("FAIL idle_op: got %h, required 000", OP);
    end

    // Junk, comma, data: first lock.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_sym(CP);
    send_sym(10'h2AA);

    // Aligned alternating commas.
    for (int k = 0; k < 20; k++) send_sym((k % 2 == 0) ? CP : CN);

    // Three commas at +4: lock lost, then relock on a fresh comma.
    send_rand_bits(4);
    for (int k = 0; k < 3; k++) send_sym(CP);
    send_sym(10'h2AA);
    send_sym(CN);
    send_sym(10'h2AA);

    // Two misses, aligned comma clears the count, two more misses.
    send_rand_bits(4);
    send_sym(CP); send_sym(CN);
    send_rand_bits(6);
    send_sym(CP);
    send_rand_bits(4);
    send_sym(CN); send_sym(CP);
    send_rand_bits(6);
    send_sym(10'h2AA);

    // Random traffic with occasional bit slips.
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0:       send_sym(CP);
        1:       send_sym(CN);
        default: begin
          v = 10'($urandom_range(0, 1023));
          send_sym(v);
        end
      endcase
      if ($urandom_range(0, 9) == 0) send_rand_bits($urandom_range(1, 9));
    end

    // Reset mid-symbol while locked, then relock at a new phase.
    send_sym(CP);
    send_rand_bits(5);
    do_reset();
    send_rand_bits(7);
    send_sym(CN);
    for (int k = 0; k < 5; k++) send_sym(10'($urandom_range(0, 1023)));
    send_sym(CP);

    for (int k = 0; k < 30; k++) send_bit(1'b0);
    repeat (3) @(negedge CLOCK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
